// File: rtl/countdown_ctrl_if.sv
// rtl/countdown_ctrl_if.sv - board-side signal bundle between countdown_ctrl and its surroundings
interface countdown_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             tick;
  logic             start_btn;
  logic             pause_btn;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic [1:0]       state;
  logic             run;
  logic             done;

  // Board/top level drives the divider tick, buttons and switches
  modport master (
    output tick, start_btn, pause_btn, load_val,
    input  count, state, run, done
  );

  // The sequencer consumes them and reports count/state
  modport slave (
    input  tick, start_btn, pause_btn, load_val,
    output count, state, run, done
  );
endinterface

// File: rtl/countdown_ctrl.sv
// rtl/countdown_ctrl.sv - run/pause/abort sequencer owning the countdown register
// Button conditioner: raw async button -> synchronised, debounced, one-clk rising pulse.
module countdown_btn_cond #(
  parameter int DB_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);
  localparam int CW = $clog2(DB_LEN + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] db_cnt;

  // Two-flop synchroniser against metastability on the raw button
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after DB_LEN consecutive disagreeing samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level  <= 1'b0;
      db_cnt <= '0;
    end else if (sync2 == level) begin
      db_cnt <= '0;
    end else if (db_cnt == CW'(DB_LEN - 1)) begin
      level  <= sync2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Registered one-shot on the debounced press; release produces nothing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_d <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      level_d <= level;
      pulse   <= level & ~level_d;
    end
  end
endmodule

module countdown_ctrl #(
  parameter int WIDTH  = 4,
  parameter int DB_LEN = 4
) (
  input  logic                clk,
  input  logic                reset,
  countdown_ctrl_if.slave     bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             run_q;
  logic             done_q;
  logic             start_p;
  logic             pause_p;

  countdown_btn_cond #(.DB_LEN(DB_LEN)) u_start_cond (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.start_btn),
    .pulse (start_p)
  );

  countdown_btn_cond #(.DB_LEN(DB_LEN)) u_pause_cond (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.pause_btn),
    .pulse (pause_p)
  );

  // Next state and next count; a terminal tick beats a pause, an abort beats a resume
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        count_d = bus.load_val;
        if (start_p) begin
          state_d = (bus.load_val == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.tick && (count_q != '0)) begin
          count_d = count_q - 1'b1;
        end
        if (bus.tick && (count_q == WIDTH'(1))) begin
          state_d = DONE;
        end else if (pause_p) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (start_p) begin
          state_d = IDLE;
        end else if (pause_p) begin
          state_d = RUN;
        end
      end
      DONE: begin
        count_d = '0;
        if (start_p) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // State, count and the decoded flags all update on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      run_q   <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  assign bus.count = count_q;
  assign bus.state = state_q;
  assign bus.run   = run_q;
  assign bus.done  = done_q;
endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Run/pause/abort sequencer for the 1 Hz countdown datapath: owns the WIDTH-bit down-count register and advances it only on divider ticks while running. Conditions two raw push buttons (synchronise, debounce, one-pulse) and exposes state, run-enable and done flags for the board top level. Sits between the 50 MHz-to-1 Hz frequency divider (tick source) and the LED/7-segment display of the count.

## Interface
- WIDTH, 4, count/load width in bits
- DB_LEN, 4, consecutive clk edges a synchronised button level must hold before it is accepted (≥2)

- clk  in  1  system clock (board clock)
- reset  in  1  asynchronous, active-low; all registers cleared while low
- tick  in  1  one-clk-wide enable pulse from the frequency divider (1 Hz nominal)
- start_btn  in  1  raw asynchronous push button, active-high
- pause_btn  in  1  raw asynchronous push button, active-high
- load_val  in  WIDTH  countdown start value (switches)
- count  out  WIDTH  current count, registered
- state  out  2  FSM state: IDLE=00, RUN=01, PAUSE=10, DONE=11
- run  out  1  high iff state==RUN (gates divider/LED blink)
- done  out  1  high iff state==DONE

## Operation
- Button conditioning (per button, identical): 2-flop synchroniser -> debounced level -> rising-edge one-pulse (start_p, pause_p). Debounced level takes the synchroniser value after it has differed from the level on DB_LEN consecutive edges; counter clears on any agreement. Pulse is 1 clk, only on debounced 0->1. Release path debounced identically, no pulse.
- IDLE: count <= load_val every edge. start_p: load_val==0 -> DONE, else -> RUN. pause_p ignored.
- RUN: tick -> count <= count-1; if count==1 at that edge, also -> DONE (count becomes 0). pause_p -> PAUSE. start_p ignored. tick and pause_p same edge: decrement applied and state -> PAUSE (or DONE if count was 1; DONE wins).
- PAUSE: count held. pause_p -> RUN. start_p -> IDLE (abort). Both same edge: start_p wins -> IDLE.
- DONE: count held at 0. start_p -> IDLE. pause_p ignored.
- tick ignored in every state but RUN. Count never decrements below 0; no wrap-around.
- load_val changes outside IDLE have no effect.

## Timing
- Reset (async assert, synchronous release by board): state=IDLE, count=0, run=0, done=0, all synchroniser/debounce/pulse regs 0. First edge after release: count=load_val.
- All outputs registered; state, run, done change on the same edge.
- Button latency: raw high stable before edge E0 -> press pulse high for exactly the cycle after edge E0+DB_LEN+2. Glitch shorter than DB_LEN edges produces no pulse.
- Pulse-to-state: state changes on the edge where the pulse is sampled high (1-cycle).
- RUN-to-first-decrement: the tick must be sampled at an edge where state is already RUN; a tick coincident with the IDLE->RUN edge is not counted.
- Countdown of N (N≥1) takes exactly N ticks from entering RUN; done rises on the edge sampling the Nth tick.
- reset low mid-count: immediate return to IDLE/count=0 regardless of state or pending pulses.

## Test plan
- Reset: hold reset=0 with load_val=9, tick toggling -> count=0, state=00, run=0, done=0; one edge after release count=9.
- Full countdown: load_val=3, clean start press, 3 ticks -> count 3,2,1,0 on successive ticks, state=11, done=1 on 3rd tick edge; 4th tick leaves count=0.
- Debounce: DB_LEN=4, start_btn high for 3 edges then low -> no transition; high for 4+ edges -> single pulse exactly at edge E0+6, state IDLE->RUN.
- Pause/abort: load_val=5, start, 2 ticks (count=3), pause -> state=10, ticks ignored, count=3; pause -> RUN, tick -> 2; pause, start -> IDLE, count=load_val.
- Simultaneous events: RUN with count=1, tick and pause_p same edge -> DONE, count=0; PAUSE with start_p and pause_p same edge -> IDLE.
- Zero load and mid-run reset: load_val=0, start -> DONE directly, done=1; in RUN at count=6 assert reset -> state=00, count=0 asynchronously.
